ifu_fetch_ctrl: RTL and testbench

Parametrised fetch controller for the frontend. It generates the fetch PC and issues block-aligned fetch requests over a valid/ready channel, with one request outstanding at a time. Each returned fetch block is split into per-instruction entries, truncated at the first predicted-taken slot, and written into an internal fetch queue. The decode side pops that queue one instruction per cycle. Redirects flush the queue and squash any in-flight response.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fetch_queue.sv | 49 ++++
 rtl/ifu_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch unit: FSM states and the fetch-queue entry.
// PCs are carried at PC_MAX width inside the queue and sized back down at the top.
package ifu_pkg;
  localparam int INST_WIDTH = 32;
  localparam int PC_MAX     = 64;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} ifu_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_MAX-1:0]     pc;
    logic                  pred_taken;
    logic [PC_MAX-1:0]     pred_target;
  } fq_entry_t;
endpackage

// File: rtl/ifu_fetch_queue.sv
// Circular fetch queue: up to FETCH_WIDTH compacted writes per cycle, one pop,
// synchronous flush that wins over both.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int FQ_DEPTH    = 8
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  i_flush,
  input  logic [$clog2(FETCH_WIDTH):0]          i_enq_n,
  input  fq_entry_t [FETCH_WIDTH-1:0]           i_enq_data,
  input  logic                                  i_pop,
  output fq_entry_t                             o_head,
  output logic [$clog2(FQ_DEPTH+1)-1:0]         o_count
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH+1);

  fq_entry_t         r_mem [FQ_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;

  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (!i_flush && i < int'(i_enq_n))
        r_mem[r_wptr + PW'(i)] <= i_enq_data[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(i_enq_n);
      r_rptr  <= r_rptr + PW'(i_pop);
      r_count <= r_count + CW'(i_enq_n) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: block-aligned requests, taken-slot truncation and queue fill.
// Optional perf counters are built when IFU_PERF_CNT_EN is defined.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int PC_WIDTH    = 64,
  parameter int FETCH_WIDTH = 4,
  parameter int FQ_DEPTH    = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [PC_WIDTH-1:0]               boot_addr,
  input  logic                              redirect_valid,
  input  logic [PC_WIDTH-1:0]               redirect_target,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic [PC_WIDTH-1:0]               req_addr,
  input  logic                              resp_valid,
  input  logic [32*FETCH_WIDTH-1:0]         resp_data,
  input  logic [FETCH_WIDTH-1:0]            resp_pred_taken,
  input  logic [PC_WIDTH-1:0]               resp_pred_target,
  output logic                              deq_valid,
  input  logic                              deq_ready,
  output logic [31:0]                       deq_inst,
  output logic [PC_WIDTH-1:0]               deq_pc,
  output logic                              deq_pred_taken,
  output logic [PC_WIDTH-1:0]               deq_pred_target,
  output logic [$clog2(FQ_DEPTH+1)-1:0]     fq_count
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_fq_full_cycles,
  output logic [31:0]                       perf_squashed_resp
`endif
);
  localparam int OFF = $clog2(4*FETCH_WIDTH);
  localparam int SW  = $clog2(FETCH_WIDTH);
  localparam int NW  = SW + 1;

  ifu_state_e                  r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]         r_fetch_pc, w_fetch_pc_nxt, w_next_pc;
  logic                        w_space, w_req_fire, w_enq, w_pop, w_hit, w_nonempty;
  logic [SW-1:0]               w_start, w_end;
  logic [NW-1:0]               w_n_enq;
  fq_entry_t [FETCH_WIDTH-1:0] w_enq_data;
  fq_entry_t                   w_head;

  assign req_addr   = {r_fetch_pc[PC_WIDTH-1:OFF], {OFF{1'b0}}};
  assign w_start    = r_fetch_pc[OFF-1:2];
  assign w_space    = (FQ_DEPTH - int'(fq_count)) >= FETCH_WIDTH;
  assign req_valid  = (r_state == REQ) && w_space;
  assign w_req_fire = req_valid && req_ready;
  assign w_enq      = (r_state == WAIT) && resp_valid && !redirect_valid;
  assign w_nonempty = (fq_count != '0);
  assign deq_valid  = w_nonempty && !redirect_valid;
  assign w_pop      = deq_valid && deq_ready;

  // Descending scan leaves the lowest taken slot at or after the start slot.
  always_comb begin
    w_end = SW'(FETCH_WIDTH-1);
    w_hit = 1'b0;
    for (int i = FETCH_WIDTH-1; i >= 0; i--)
      if (i >= int'(w_start) && resp_pred_taken[i]) begin
        w_end = SW'(i);
        w_hit = 1'b1;
      end
  end

  assign w_n_enq   = w_enq ? (NW'(w_end) - NW'(w_start) + NW'(1)) : '0;
  assign w_next_pc = w_hit ? resp_pred_target : req_addr + PC_WIDTH'(4*FETCH_WIDTH);

  // Compaction: queue lane j carries block slot start+j.
  always_comb begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      w_enq_data[j] = '0;
      if (int'(w_start) + j < FETCH_WIDTH) begin
        w_enq_data[j].inst = resp_data[32*(int'(w_start)+j) +: 32];
        w_enq_data[j].pc   = PC_MAX'(req_addr + PC_WIDTH'(4*(int'(w_start)+j)));
        if (SW'(int'(w_start)+j) == w_end) begin
          w_enq_data[j].pred_taken  = w_hit;
          w_enq_data[j].pred_target = PC_MAX'(resp_pred_target);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    unique case (r_state)
      IDLE:  begin w_state_nxt = REQ; w_fetch_pc_nxt = boot_addr; end
      REQ:   if (w_req_fire) w_state_nxt = WAIT;
      WAIT:  if (resp_valid) begin w_state_nxt = REQ; w_fetch_pc_nxt = w_next_pc; end
      DRAIN: if (resp_valid) w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase
    // A redirect keeps DRAIN only while a stale response is still owed.
    if (redirect_valid) begin
      w_fetch_pc_nxt = redirect_target;
      if (((r_state == WAIT || r_state == DRAIN) && !resp_valid) ||
          (r_state == REQ && w_req_fire))
        w_state_nxt = DRAIN;
      else
        w_state_nxt = REQ;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  ifu_fetch_queue #(.FETCH_WIDTH(FETCH_WIDTH), .FQ_DEPTH(FQ_DEPTH)) u_fq (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_flush    (redirect_valid),
    .i_enq_n    (w_n_enq),
    .i_enq_data (w_enq_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (fq_count)
  );

  assign deq_inst        = w_nonempty ? w_head.inst : '0;
  assign deq_pc          = w_nonempty ? w_head.pc[PC_WIDTH-1:0] : '0;
  assign deq_pred_taken  = w_nonempty && w_head.pred_taken;
  assign deq_pred_target = w_nonempty ? w_head.pred_target[PC_WIDTH-1:0] : '0;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_full, r_perf_sq;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_full <= '0;
      r_perf_sq   <= '0;
    end else begin
      if (r_state == REQ && !w_space && r_perf_full != '1)
        r_perf_full <= r_perf_full + 32'd1;
      if (resp_valid && (r_state == DRAIN || (r_state == WAIT && redirect_valid)) &&
          r_perf_sq != '1)
        r_perf_sq <= r_perf_sq + 32'd1;
    end
  end
  assign perf_fq_full_cycles = r_perf_full;
  assign perf_squashed_resp  = r_perf_sq;
`endif
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a request/response-level queue model
// checked every cycle, plus literal expectations for the plan scenarios.
module tb_ifu_fetch_ctrl;
  localparam int FW  = 4;
  localparam int FQ  = 8;
  localparam int PCW = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [PCW-1:0]    boot_addr, redirect_target, req_addr, resp_pred_target;
  logic [PCW-1:0]    deq_pc, deq_pred_target;
  logic              redirect_valid, req_valid, req_ready, resp_valid;
  logic [32*FW-1:0]  resp_data;
  logic [FW-1:0]     resp_pred_taken;
  logic              deq_valid, deq_ready, deq_pred_taken;
  logic [31:0]       deq_inst;
  logic [$clog2(FQ+1)-1:0] fq_count;

  ifu_fetch_ctrl #(.PC_WIDTH(PCW), .FETCH_WIDTH(FW), .FQ_DEPTH(FQ)) dut (
    .clock(clock), .reset_n(reset_n), .boot_addr(boot_addr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_pred_taken(resp_pred_taken), .resp_pred_target(resp_pred_target),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .deq_pred_taken(deq_pred_taken),
    .deq_pred_target(deq_pred_target), .fq_count(fq_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Model: expected queue contents plus the fetch PC and outstanding-request status.
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        tk;
    logic [63:0] tgt;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [63:0] m_pc, m_out_pc, base;
  bit          m_out, m_sq, hit;

  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      m_out = 0;
      m_sq  = 0;
      m_pc  = boot_addr;
    end else begin
      chk("fq_count", 64'(fq_count), 64'(q.size()));
      chk("deq_valid", 64'(deq_valid), 64'(q.size() != 0 && !redirect_valid));
      if (q.size() != 0) begin
        chk("deq_inst", 64'(deq_inst), 64'(q[0].inst));
        chk("deq_pc", deq_pc, q[0].pc);
        chk("deq_pred_taken", 64'(deq_pred_taken), 64'(q[0].tk));
        chk("deq_pred_target", deq_pred_target, q[0].tgt);
      end
      if (q.size() != 0 && !redirect_valid && deq_ready) void'(q.pop_front());
      if (resp_valid && m_out) begin
        if (!m_sq && !redirect_valid) begin
          base = m_out_pc & ~64'hF;
          hit  = 0;
          for (int k = int'(m_out_pc[3:2]); k < FW && !hit; k++) begin
            e.inst = resp_data[32*k +: 32];
            e.pc   = base + 64'(4*k);
            e.tk   = resp_pred_taken[k];
            e.tgt  = (e.tk || k == FW-1) ? resp_pred_target : 64'h0;
            q.push_back(e);
            hit = e.tk;
          end
          m_pc = hit ? resp_pred_target : base + 64'h10;
        end
        m_out = 0;
      end
      if (req_valid && req_ready) begin
        chk("req_addr", req_addr, m_pc & ~64'hF);
        chk("req_space", 64'(q.size() <= FQ-FW), 64'd1);
        m_out    = 1;
        m_sq     = 0;
        m_out_pc = m_pc;
      end
      if (redirect_valid) begin
        m_pc = redirect_target;
        q.delete();
        if (m_out) m_sq = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(output logic [63:0] a);
    bit got;
    got = 0;
    a = '0;
    req_ready = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      if (req_valid) begin a = req_addr; got = 1; end
      cyc();
    end
    req_ready = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL req_timeout got=none exp=request");
    end
  endtask

  task automatic drive_resp(input logic [3:0] tk, input logic [63:0] tgt, input logic [31:0] seed);
    resp_valid       = 1'b1;
    resp_pred_taken  = tk;
    resp_pred_target = tgt;
    for (int i = 0; i < FW; i++) resp_data[32*i +: 32] = seed + 32'(i);
  endtask

  task automatic respond(input logic [3:0] tk, input logic [63:0] tgt, input logic [31:0] seed);
    drive_resp(tk, tgt, seed);
    cyc();
    resp_valid      = 1'b0;
    resp_pred_taken = '0;
  endtask

  task automatic pop_n(input int n);
    deq_ready = 1'b1;
    repeat (n) cyc();
    deq_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] a;

  initial begin
    reset_n = 1'b0; boot_addr = 64'h8000_0000;
    redirect_valid = 0; redirect_target = '0; req_ready = 0;
    resp_valid = 0; resp_data = '0; resp_pred_taken = '0; resp_pred_target = '0;
    deq_ready = 0;
    repeat (3) cyc();
    chk("rst_req_valid", 64'(req_valid), 0);
    chk("rst_deq_valid", 64'(deq_valid), 0);
    chk("rst_fq_count", 64'(fq_count), 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_deq_pc", deq_pc, 0);
    reset_n = 1'b1;
    cyc();

    // 1: boot fetch, full block
    wait_req(a);
    chk("t1_addr", a, 64'h8000_0000);
    respond(4'b0000, 64'h0, 32'h1000_0000);
    chk("t1_cnt", 64'(fq_count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc", deq_pc, 64'h8000_0000 + 64'(4*i));
      pop_n(1);
    end
    chk("t1_empty", 64'(fq_count), 0);
    wait_req(a);
    chk("t1_next", a, 64'h8000_0010);

    // 2: redirect to mid-block PC; stale response dropped
    redirect_valid = 1'b1; redirect_target = 64'h8000_0108;
    cyc();
    redirect_valid = 1'b0;
    respond(4'b1111, 64'hDEAD_0000, 32'h2000_0000);
    chk("t2_drop", 64'(fq_count), 0);
    wait_req(a);
    chk("t2_addr", a, 64'h8000_0100);
    respond(4'b0000, 64'h0, 32'h2100_0000);
    chk("t2_cnt", 64'(fq_count), 2);
    chk("t2_pc0", deq_pc, 64'h8000_0108);
    chk("t2_inst0", 64'(deq_inst), 64'h2100_0002);
    pop_n(1);
    chk("t2_pc1", deq_pc, 64'h8000_010C);
    pop_n(1);

    // 3: taken slot 1 truncates block
    wait_req(a);
    chk("t3_addr", a, 64'h8000_0110);
    respond(4'b0110, 64'h8000_0400, 32'h3000_0000);
    chk("t3_cnt", 64'(fq_count), 2);
    chk("t3_pc0", deq_pc, 64'h8000_0110);
    chk("t3_tk0", 64'(deq_pred_taken), 0);
    pop_n(1);
    chk("t3_pc1", deq_pc, 64'h8000_0114);
    chk("t3_tk1", 64'(deq_pred_taken), 1);
    chk("t3_tgt1", deq_pred_target, 64'h8000_0400);
    pop_n(1);
    wait_req(a);
    chk("t3_next", a, 64'h8000_0400);

    // 4: redirect in WAIT, response 3 cycles later is dropped
    redirect_valid = 1'b1; redirect_target = 64'h9000_0000;
    cyc();
    redirect_valid = 1'b0;
    cyc(); cyc();
    respond(4'b0000, 64'h0, 32'h4000_0000);
    chk("t4_drop", 64'(fq_count), 0);
    wait_req(a);
    chk("t4_addr", a, 64'h9000_0000);

    // 5: fill queue, request held until space frees
    respond(4'b0000, 64'h0, 32'h5000_0000);
    wait_req(a);
    chk("t5_addr", a, 64'h9000_0010);
    respond(4'b0000, 64'h0, 32'h5100_0000);
    chk("t5_full", 64'(fq_count), 8);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold", 64'(req_valid), 0);
      cyc();
    end
    deq_ready = 1'b1;
    repeat (3) cyc();
    chk("t5_still", 64'(req_valid), 0);
    cyc();
    deq_ready = 1'b0;
    chk("t5_cnt4", 64'(fq_count), 4);
    chk("t5_rise", 64'(req_valid), 1);

    // 6: redirect coincident with response, queue holding 3
    wait_req(a);
    chk("t6_addr0", a, 64'h9000_0020);
    pop_n(1);
    chk("t6_cnt3", 64'(fq_count), 3);
    redirect_valid = 1'b1; redirect_target = 64'hA000_0000;
    drive_resp(4'b0000, 64'h0, 32'h6000_0000);
    cyc();
    redirect_valid = 1'b0; resp_valid = 1'b0;
    chk("t6_flush", 64'(fq_count), 0);
    wait_req(a);
    chk("t6_addr", a, 64'hA000_0000);
    respond(4'b0000, 64'h0, 32'h6100_0000);
    chk("t6_cnt", 64'(fq_count), 4);
    pop_n(4);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
